// File: rtl/fmt_pkt_rx.sv
// fmt_pkt_rx: downstream packet sink for the MCDF formatter output.
// Reserves FIFO space before granting the formatter, captures one start..end
// packet at a time into a first-word-fall-through FIFO of {chid, last, data}
// entries, drains it to a valid/ready stream and flags length/timeout errors.
// Optional build macro FMT_RX_STATS_EN: when defined, per-channel completed
// packet counters are built; otherwise the counter ports are tied to zero.
module fmt_pkt_rx #(
    parameter int DEPTH   = 64,
    parameter int TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        fmt_req_i,
    input  logic [1:0]  fmt_chid_i,
    input  logic [5:0]  fmt_length_i,
    input  logic [31:0] fmt_data_i,
    input  logic        fmt_start_i,
    input  logic        fmt_end_i,
    output logic        fmt_grant_o,
    output logic [31:0] rx_data_o,
    output logic [1:0]  rx_chid_o,
    output logic        rx_last_o,
    output logic        rx_valid_o,
    input  logic        rx_ready_i,
    output logic        err_len_o,
    output logic        err_to_o,
    output logic [15:0] pkt_cnt0_o,
    output logic [15:0] pkt_cnt1_o,
    output logic [15:0] pkt_cnt2_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {IDLE, GRANT, WAIT_S, DATA, DONE} state_t;

    state_t          state;
    logic [1:0]      chid_q;
    logic [5:0]      len_q;
    logic [7:0]      wcnt;
    logic [TW-1:0]   tcnt;

    logic [34:0]     mem [DEPTH];
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   free;

    logic            push;
    logic            push_last;
    logic            drop_end;
    logic            pop;

    assign free       = CW'(DEPTH) - count;
    assign rx_valid_o = (count != '0);
    assign pop        = rx_valid_o && rx_ready_i;

    // Head fields fall through from storage; forced to zero while empty so
    // nothing undefined leaks out after reset.
    assign rx_data_o  = rx_valid_o ? mem[rptr][31:0] : '0;
    assign rx_last_o  = rx_valid_o ? mem[rptr][32]   : 1'b0;
    assign rx_chid_o  = rx_valid_o ? mem[rptr][34:33] : '0;

    // Decide per cycle whether the incoming word is stored, and whether a
    // dropped end word must retro-flag the last stored word of the packet.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        push      = 1'b0;
        push_last = 1'b0;
        drop_end  = 1'b0;
        case (state)
            WAIT_S: begin
                if (fmt_start_i) begin
                    push      = 1'b1;
                    push_last = fmt_end_i;
                end
            end
            DATA: begin
                if (wcnt < {2'b00, len_q}) begin
                    push      = 1'b1;
                    push_last = fmt_end_i;
                end else if (fmt_end_i) begin
                    drop_end  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // FIFO storage writes; a dropped end word sets the last flag of the most
    // recently written entry, which is always the len-th word of the packet.
    always_ff @(posedge clk_i) begin
        // NOTE: the storage array is deliberately not reset; emptiness is carried by the pointers and count.
        if (push) begin
            mem[wptr] <= {chid_q, push_last, fmt_data_i};
        end else if (drop_end) begin
            mem[wptr - 1'b1][32] <= 1'b1;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop keep count.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Packet FSM: reserve, grant, wait for start, collect words, report.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state       <= IDLE;
            chid_q      <= '0;
            len_q       <= '0;
            wcnt        <= '0;
            tcnt        <= '0;
            fmt_grant_o <= 1'b0;
            err_len_o   <= 1'b0;
            err_to_o    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            fmt_grant_o <= 1'b0;
            err_len_o   <= 1'b0;
            err_to_o    <= 1'b0;
            case (state)
                IDLE: begin
                    if (fmt_req_i && (free >= CW'(fmt_length_i))) begin
                        chid_q      <= fmt_chid_i;
                        len_q       <= fmt_length_i;
                        fmt_grant_o <= 1'b1;
                        state       <= GRANT;
                    end
                end
                GRANT: begin
                    wcnt  <= '0;
                    tcnt  <= '0;
                    state <= WAIT_S;
                end
                WAIT_S: begin
                    tcnt <= tcnt + 1'b1;
                    if (fmt_start_i) begin
                        wcnt  <= 8'd1;
                        state <= fmt_end_i ? DONE : DATA;
                    end else if (tcnt == TW'(TIMEOUT - 1)) begin
                        err_to_o <= 1'b1;
                        state    <= IDLE;
                    end
                end
                DATA: begin
                    wcnt <= wcnt + 1'b1;
                    if (fmt_end_i) state <= DONE;
                end
                DONE: begin
                    err_len_o <= (wcnt != {2'b00, len_q});
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FMT_RX_STATS_EN
    logic [15:0] cnt0, cnt1, cnt2;

    // Completed-packet counters per channel; channel 3 is not counted.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt0 <= '0;
            cnt1 <= '0;
            cnt2 <= '0;
        end else if (state == DONE) begin
            case (chid_q)
                2'd0:    cnt0 <= cnt0 + 1'b1;
                2'd1:    cnt1 <= cnt1 + 1'b1;
                2'd2:    cnt2 <= cnt2 + 1'b1;
                default: ;
            endcase
        end
    end

    assign pkt_cnt0_o = cnt0;
    assign pkt_cnt1_o = cnt1;
    assign pkt_cnt2_o = cnt2;
`else
    assign pkt_cnt0_o = 16'h0;
    assign pkt_cnt1_o = 16'h0;
    assign pkt_cnt2_o = 16'h0;
`endif

endmodule
